// File: rtl/data_sram_slave_pkg.sv
// Shared types and constants for the data SRAM slave: size encodings,
// response queue entry layout and the random-delay LFSR seed/step.
package data_sram_slave_pkg;

  localparam logic [1:0]  SIZE_B    = 2'd0;
  localparam logic [1:0]  SIZE_H    = 2'd1;
  localparam logic [1:0]  SIZE_W    = 2'd2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Wide enough for LATENCY-1 (max 6) plus the random extra (max 3).
  localparam int CD_W = 4;

  typedef struct packed {
    logic            is_load;
    logic [31:0]     rdata;
    logic [CD_W-1:0] countdown;
  } resp_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/data_sram_if.sv
// Initiator-side data SRAM request/response bundle.
interface data_sram_if;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface

// File: rtl/data_sram_resp_fifo.sv
// In-order response queue; every entry counts its own delay down so the
// head can issue as soon as it is ready.
module data_sram_resp_fifo
  import data_sram_slave_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic [2:0]  occupancy
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  resp_entry_t      q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = q[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      // Stale slots also count down; harmless since they are overwritten on push.
      for (int i = 0; i < QDEPTH; i++) begin
        if (q[i].countdown != '0)
          q[i].countdown <= q[i].countdown - 1'b1;
      end
      if (push) begin
        q[wr_ptr] <= push_entry;
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 3'd1;
        2'b01:   occupancy <= occupancy - 3'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_slave.sv
// Data SRAM slave model with byte-lane stores and queued, ordered responses.
// Optional random response delay / accept throttling: DATA_SRAM_RAND_DELAY_EN.
module data_sram_slave
  import data_sram_slave_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 2
) (
  input logic        clk,
  input logic        resetn,
  data_sram_if.slave bus
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic [2:0]        occupancy;
  resp_entry_t       head;
  resp_entry_t       push_entry;
  logic              accept;
  logic              space_ok;
  logic              lfsr_ok;
  logic              head_ready;
  logic [CD_W-1:0]   cd_load;
  logic              unused_ok;

  assign word_idx = bus.data_sram_addr[ADDR_W+1:2];
  assign space_ok = occupancy < 3'(QDEPTH);

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_next(lfsr);
  end

  assign lfsr_ok = ~lfsr[0];
  assign cd_load = CD_W'(LATENCY - 1) + CD_W'(lfsr[2:1]);
`else
  assign lfsr_ok = 1'b1;
  assign cd_load = CD_W'(LATENCY - 1);
`endif

  assign bus.data_sram_addr_ok = resetn & space_ok & lfsr_ok;
  assign accept                = bus.data_sram_req & bus.data_sram_addr_ok;

  // Loads sample the array before this edge's write; only one request per cycle.
  assign push_entry.is_load   = ~bus.data_sram_wr;
  assign push_entry.rdata     = bus.data_sram_wr ? 32'd0 : mem[word_idx];
  assign push_entry.countdown = cd_load;

  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wstrb[i])
          mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  data_sram_resp_fifo #(.QDEPTH(QDEPTH)) u_resp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (bus.data_sram_data_ok),
    .head       (head),
    .occupancy  (occupancy)
  );

  assign head_ready            = (occupancy != 3'd0) && (head.countdown == '0);
  assign bus.data_sram_data_ok = resetn & head_ready;
  assign bus.data_sram_rdata   = (bus.data_sram_data_ok && head.is_load) ? head.rdata : 32'd0;

  // Size is informational and the address bits outside the word index alias.
  assign unused_ok = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0],
                       (bus.data_sram_size inside {SIZE_B, SIZE_H, SIZE_W})};

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: directed and random traffic checked against a
// word-array reference and an expected-response queue.
module tb_data_sram_slave;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int QD    = 2;
`ifdef DATA_SRAM_RAND_DELAY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic resetn_a;
  logic resetn_b;
  always #5 clk = ~clk;

  data_sram_if bus_a ();
  data_sram_if bus_b ();

  data_sram_slave #(.ADDR_W(10), .LATENCY(LAT_A), .QDEPTH(QD)) dut_a (
    .clk(clk), .resetn(resetn_a), .bus(bus_a));
  data_sram_slave #(.ADDR_W(10), .LATENCY(LAT_B), .QDEPTH(QD)) dut_b (
    .clk(clk), .resetn(resetn_b), .bus(bus_b));

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [1024];
  logic        acc_a;
  logic [31:0] resp_rdata;
  int          resp_lat;
  logic        sb_acc, sb_addr_ok, sb_data_ok;
  logic [31:0] sb_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle on DUT a: observe at negedge, score responses, record accepts.
  task automatic tick_a();
    exp_t       e;
    logic [9:0] idx;
    @(negedge clk);
    acc_a = bus_a.data_sram_req & bus_a.data_sram_addr_ok;
`ifndef DATA_SRAM_RAND_DELAY_EN
    check("a_addr_ok", 32'(bus_a.data_sram_addr_ok), 32'(exp_q.size() < QD));
    check("a_data_ok", 32'(bus_a.data_sram_data_ok),
          32'(exp_q.size() != 0 && (cyc - exp_q[0].cyc) == LAT_A));
`else
    check("a_addr_ok_full", 32'(bus_a.data_sram_addr_ok && exp_q.size() >= QD), 32'd0);
`endif
    if (bus_a.data_sram_data_ok) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL a_spurious_data_ok observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        e          = exp_q.pop_front();
        resp_rdata = bus_a.data_sram_rdata;
        resp_lat   = cyc - e.cyc;
        check("a_rdata", resp_rdata, e.rdata);
        checks++;
        assert (resp_lat >= LAT_A && resp_lat <= LAT_A + EXTRA) else begin
          errors++;
          $error("FAIL a_latency observed=%0d expected=%0d..%0d", resp_lat, LAT_A, LAT_A + EXTRA);
        end
      end
    end
    if (acc_a) begin
      idx   = bus_a.data_sram_addr[11:2];
      e.cyc = cyc;
      if (bus_a.data_sram_wr) begin
        for (int i = 0; i < 4; i++)
          if (bus_a.data_sram_wstrb[i]) ref_mem[idx][8*i +: 8] = bus_a.data_sram_wdata[8*i +: 8];
        e.rdata = 32'd0;
      end else begin
        e.rdata = ref_mem[idx];
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue_a(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus_a.data_sram_req   = 1'b1;
    bus_a.data_sram_wr    = wr;
    bus_a.data_sram_size  = 2'd2;
    bus_a.data_sram_wstrb = strb;
    bus_a.data_sram_addr  = addr;
    bus_a.data_sram_wdata = wdata;
    acc_a = 1'b0;
    for (int n = 0; n < 50 && !acc_a; n++) tick_a();
    check("a_accept_timeout", 32'(acc_a), 32'd1);
    bus_a.data_sram_req = 1'b0;
  endtask

  task automatic drain_a();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick_a();
    check("a_drain", exp_q.size(), 32'd0);
  endtask

  task automatic tick_b();
    @(negedge clk);
    sb_addr_ok = bus_b.data_sram_addr_ok;
    sb_data_ok = bus_b.data_sram_data_ok;
    sb_rdata   = bus_b.data_sram_rdata;
    sb_acc     = bus_b.data_sram_req & sb_addr_ok;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_b(input logic [31:0] addr, input logic [31:0] wdata);
    bus_b.data_sram_req   = 1'b1;
    bus_b.data_sram_wr    = 1'b1;
    bus_b.data_sram_wstrb = 4'hF;
    bus_b.data_sram_addr  = addr;
    bus_b.data_sram_wdata = wdata;
    sb_acc = 1'b0;
    for (int n = 0; n < 50 && !sb_acc; n++) tick_b();
    check("b_accept_timeout", 32'(sb_acc), 32'd1);
    bus_b.data_sram_req = 1'b0;
  endtask

  localparam int ACC_T [4]  = '{0, 1, 4, 5};
  localparam int RESP_T [4] = '{3, 4, 7, 8};

  initial begin
    int          n_acc;
    int          nb, nr;
    int          acc_t [4];
    int          resp_t [4];
    logic [31:0] resp_d [4];
    logic        ok_hist [40];
    logic [31:0] r;
    logic [3:0]  w;

    resetn_a = 1'b0;
    resetn_b = 1'b0;
    bus_a.data_sram_req = 1'b0; bus_a.data_sram_wr = 1'b0; bus_a.data_sram_size = 2'd2;
    bus_a.data_sram_wstrb = 4'h0; bus_a.data_sram_addr = '0; bus_a.data_sram_wdata = '0;
    bus_b.data_sram_req = 1'b0; bus_b.data_sram_wr = 1'b0; bus_b.data_sram_size = 2'd2;
    bus_b.data_sram_wstrb = 4'h0; bus_b.data_sram_addr = '0; bus_b.data_sram_wdata = '0;

    repeat (2) @(posedge clk);
    bus_a.data_sram_req = 1'b1;
    bus_b.data_sram_req = 1'b1;
    @(negedge clk);
    check("rst_a_addr_ok", 32'(bus_a.data_sram_addr_ok), 32'd0);
    check("rst_a_data_ok", 32'(bus_a.data_sram_data_ok), 32'd0);
    check("rst_a_rdata", bus_a.data_sram_rdata, 32'd0);
    check("rst_b_addr_ok", 32'(bus_b.data_sram_addr_ok), 32'd0);
    check("rst_b_data_ok", 32'(bus_b.data_sram_data_ok), 32'd0);
    @(posedge clk);
    #1;
    bus_a.data_sram_req = 1'b0;
    bus_b.data_sram_req = 1'b0;
    resetn_a = 1'b1;
    resetn_b = 1'b1;

    // Give the words used by random traffic a known value.
    for (int i = 0; i < 16; i++) issue_a(1'b1, 4'hF, 32'(i * 4), $urandom);
    drain_a();

    issue_a(1'b1, 4'hF, 32'h100, 32'h12345678);
    issue_a(1'b0, 4'h0, 32'h100, 32'h0);
    drain_a();
    check("store_load_rdata", resp_rdata, 32'h12345678);
`ifndef DATA_SRAM_RAND_DELAY_EN
    check("store_load_latency", resp_lat, 32'd1);
`endif

    issue_a(1'b1, 4'b0010, 32'h100, 32'h0000AB00);
    issue_a(1'b0, 4'h0, 32'h100, 32'h0);
    drain_a();
    check("byte_lane_rdata", resp_rdata, 32'h1234AB78);

    issue_a(1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
    issue_a(1'b0, 4'h0, 32'h1000, 32'h0);
    drain_a();
    check("alias_rdata", resp_rdata, 32'hCAFEF00D);

    issue_a(1'b1, 4'h0, 32'h100, 32'hFFFFFFFF);
    issue_a(1'b0, 4'h0, 32'h100, 32'h0);
    drain_a();
    check("wstrb0_rdata", resp_rdata, 32'h1234AB78);

    n_acc = 0;
    bus_a.data_sram_req = 1'b1;
    bus_a.data_sram_wr  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bus_a.data_sram_addr = (n_acc % 2 == 1) ? 32'h0 : 32'h100;
      tick_a();
      if (acc_a) n_acc++;
    end
    bus_a.data_sram_req = 1'b0;
`ifndef DATA_SRAM_RAND_DELAY_EN
    check("b2b_accepts", n_acc, 32'd4);
`endif
    drain_a();

    n_acc = 0;
    acc_a = 1'b1;
    for (int n = 0; n < 3000 && n_acc < 100; n++) begin
      if (!bus_a.data_sram_req || acc_a) begin
        r = $urandom;
        w = 4'($urandom_range(0, 15));
        bus_a.data_sram_req   = ($urandom_range(0, 9) < 7);
        bus_a.data_sram_wr    = r[2];
        bus_a.data_sram_size  = r[4:3] % 2'd3;
        bus_a.data_sram_wstrb = 4'($urandom);
        bus_a.data_sram_addr  = {r[31:12], 6'b0, w, r[1:0]};
        bus_a.data_sram_wdata = $urandom;
      end
      tick_a();
      if (acc_a) n_acc++;
    end
    bus_a.data_sram_req = 1'b0;
    check("rand_accepts", n_acc, 32'd100);
    drain_a();

    // DUT b: four loads with the request held, queue depth 2 and latency 3.
    for (int i = 0; i < 4; i++) issue_b(32'(i * 4), 32'hB0000000 + 32'(i));
    repeat (10) tick_b();
    nb = 0;
    nr = 0;
    bus_b.data_sram_wr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bus_b.data_sram_req  = (nb < 4);
      bus_b.data_sram_addr = 32'(nb * 4);
      tick_b();
      ok_hist[t] = sb_addr_ok;
      if (sb_acc) begin
        if (nb < 4) acc_t[nb] = t;
        nb++;
      end
      if (sb_data_ok) begin
        if (nr < 4) begin
          resp_t[nr] = t;
          resp_d[nr] = sb_rdata;
        end
        nr++;
      end
    end
    bus_b.data_sram_req = 1'b0;
    check("hold_accepts", nb, 32'd4);
    check("hold_responses", nr, 32'd4);
    if (nr >= 4)
      for (int i = 0; i < 4; i++) check("hold_rdata_order", resp_d[i], 32'hB0000000 + 32'(i));
`ifndef DATA_SRAM_RAND_DELAY_EN
    check("hold_addr_ok_t2", 32'(ok_hist[2]), 32'd0);
    check("hold_addr_ok_t3", 32'(ok_hist[3]), 32'd0);
    check("hold_addr_ok_t4", 32'(ok_hist[4]), 32'd1);
    if (nb >= 4 && nr >= 4)
      for (int i = 0; i < 4; i++) begin
        check("hold_accept_cycle", acc_t[i], ACC_T[i]);
        check("hold_resp_cycle", resp_t[i], RESP_T[i]);
      end
`endif

    // Reset with two loads in flight discards them.
    nb = 0;
    bus_b.data_sram_wr = 1'b0;
    for (int t = 0; t < 40 && nb < 2; t++) begin
      bus_b.data_sram_req  = 1'b1;
      bus_b.data_sram_addr = 32'(nb * 4);
      tick_b();
      if (sb_acc) nb++;
    end
    bus_b.data_sram_req = 1'b0;
    check("flight_accepts", nb, 32'd2);
    resetn_b = 1'b0;
    tick_b();
    check("mid_rst_addr_ok", 32'(sb_addr_ok), 32'd0);
    check("mid_rst_data_ok", 32'(sb_data_ok), 32'd0);
    check("mid_rst_rdata", sb_rdata, 32'd0);
    resetn_b = 1'b1;
    tick_b();
`ifndef DATA_SRAM_RAND_DELAY_EN
    check("post_rst_addr_ok", 32'(sb_addr_ok), 32'd1);
`endif
    check("post_rst_data_ok", 32'(sb_data_ok), 32'd0);
    for (int t = 0; t < 10; t++) begin
      tick_b();
      check("post_rst_data_ok", 32'(sb_data_ok), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
